// File: rtl/video_cursor_overlay_if.sv
// Video cursor overlay bus bundle.
// Groups the incoming video stream, cursor control, bitmap write port and
// outgoing video stream so the overlay stage can be wired with one port.
//   master : upstream/controller side (drives in_*, cursor_*, bm_*; reads out_*)
//   slave  : overlay stage (reads in_*, cursor_*, bm_*; drives out_*)
interface video_cursor_overlay_if #(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480
);
    localparam int unsigned XW = $clog2(HDISP);
    localparam int unsigned YW = $clog2(VDISP);

    logic          in_hs;
    logic          in_vs;
    logic          in_blank;
    logic [23:0]   in_rgb;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic          cursor_en;
    logic [23:0]   cursor_color;
    logic          bm_we;
    logic [3:0]    bm_addr;
    logic [31:0]   bm_wdata;
    logic          out_hs;
    logic          out_vs;
    logic          out_blank;
    logic [23:0]   out_rgb;

    modport master (
        output in_hs, in_vs, in_blank, in_rgb,
        output cursor_x, cursor_y, cursor_en, cursor_color,
        output bm_we, bm_addr, bm_wdata,
        input  out_hs, out_vs, out_blank, out_rgb
    );

    modport slave (
        input  in_hs, in_vs, in_blank, in_rgb,
        input  cursor_x, cursor_y, cursor_en, cursor_color,
        input  bm_we, bm_addr, bm_wdata,
        output out_hs, out_vs, out_blank, out_rgb
    );
endinterface

// File: rtl/video_cursor_overlay.sv
// Hardware cursor overlay stage.
// Tracks the pixel coordinate of the incoming video stream, overlays a 16x16
// 2-bit-per-pixel cursor bitmap and forwards the stream with a fixed 2-cycle
// latency on all outputs. Cursor position/enable are shadowed at the VS
// falling edge so a frame is never drawn with a half-updated cursor.
// Ports:
//   pixel_clk : pixel clock
//   pixel_rst : asynchronous, active-high reset
//   vif       : slave side of the video/cursor/bitmap bundle
module video_cursor_overlay #(
    parameter int unsigned HDISP    = 800,
    parameter int unsigned VDISP    = 480,
    parameter int unsigned CUR_SIZE = 16
) (
    input logic                   pixel_clk,
    input logic                   pixel_rst,
    video_cursor_overlay_if.slave vif
);
    localparam int unsigned XW = $clog2(HDISP);
    localparam int unsigned YW = $clog2(VDISP);
    localparam logic [XW-1:0] XMAX = XW'(HDISP - 1);
    localparam logic [YW-1:0] YMAX = YW'(VDISP - 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          en_act_q;
    logic [XW-1:0] cx_q;
    logic [YW-1:0] cy_q;
    logic [31:0]   bitmap_q [16];

    // Stage 1
    logic          hs1_q, vs1_q, blank1_q, hit1_q;
    logic [1:0]    code1_q;
    logic [23:0]   rgb1_q, color1_q;
    // Stage 2
    logic          hs2_q, vs2_q, blank2_q;
    logic [23:0]   rgb2_q;

    logic          hit_d;
    logic [1:0]    code_d;
    logic [23:0]   rgb_d;
    logic [XW:0]   x_end;
    logic [YW:0]   y_end;
    logic [3:0]    dx, dy;
    logic [31:0]   row;
    logic          vs_fall, blank_fall;

    // Stage-1 registers hold the previous cycle's input, so they double as
    // edge detectors for VS and BLANK.
    assign vs_fall    = vs1_q & ~vif.in_vs;
    assign blank_fall = blank1_q & ~vif.in_blank;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (!vif.in_blank)   x_q <= '0;
            else if (x_q != XMAX) x_q <= x_q + 1'b1;

            if (!vif.in_vs)                     y_q <= '0;
            else if (blank_fall && y_q != YMAX) y_q <= y_q + 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            en_act_q <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
        end else if (vs_fall) begin
            en_act_q <= vif.cursor_en;
            cx_q     <= vif.cursor_x;
            cy_q     <= vif.cursor_y;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            for (int i = 0; i < 16; i++) bitmap_q[i] <= '0;
        end else if (vif.bm_we) begin
            bitmap_q[vif.bm_addr] <= vif.bm_wdata;
        end
    end

    always_comb begin
        // One bit wider so the cursor clips at the right/bottom edge.
        x_end  = {1'b0, cx_q} + (XW + 1)'(CUR_SIZE);
        y_end  = {1'b0, cy_q} + (YW + 1)'(CUR_SIZE);
        hit_d  = en_act_q && (x_q >= cx_q) && ({1'b0, x_q} < x_end) &&
                 (y_q >= cy_q) && ({1'b0, y_q} < y_end);
        dx     = x_q[3:0] - cx_q[3:0];
        dy     = y_q[3:0] - cy_q[3:0];
        row    = bitmap_q[dy];
        code_d = row[{dx, 1'b0} +: 2];
    end

    always_comb begin
        rgb_d = rgb1_q;
        if (!blank1_q) begin
            rgb_d = '0;
        end else if (hit1_q) begin
            case (code1_q)
                2'b01:   rgb_d = color1_q;
                2'b10:   rgb_d = ~rgb1_q;
                2'b11:   rgb_d = 24'hFFFFFF;
                default: rgb_d = rgb1_q;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            blank1_q <= 1'b0;
            hit1_q   <= 1'b0;
            code1_q  <= '0;
            rgb1_q   <= '0;
            color1_q <= '0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            blank2_q <= 1'b0;
            rgb2_q   <= '0;
        end else begin
            hs1_q    <= vif.in_hs;
            vs1_q    <= vif.in_vs;
            blank1_q <= vif.in_blank;
            hit1_q   <= hit_d;
            code1_q  <= code_d;
            rgb1_q   <= vif.in_rgb;
            color1_q <= vif.cursor_color;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            blank2_q <= blank1_q;
            rgb2_q   <= rgb_d;
        end
    end

    assign vif.out_hs    = hs2_q;
    assign vif.out_vs    = vs2_q;
    assign vif.out_blank = blank2_q;
    assign vif.out_rgb   = rgb2_q;
endmodule

// File: tb/tb_video_cursor_overlay.sv
// Directed bench for video_cursor_overlay: drives sparse frames (full 800-pixel
// lines only where pixels are inspected, 1-pixel lines elsewhere) and checks
// captured output pixels against hand-computed colours.
module tb_video_cursor_overlay;
    localparam int unsigned HDISP = 800;
    localparam int unsigned VDISP = 480;
    localparam logic [23:0] BG    = 24'h123456;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    logic pixel_clk = 1'b0;
    logic pixel_rst = 1'b1;

    video_cursor_overlay_if #(.HDISP(HDISP), .VDISP(VDISP)) vif ();

    video_cursor_overlay #(.HDISP(HDISP), .VDISP(VDISP), .CUR_SIZE(16)) dut (
        .pixel_clk (pixel_clk),
        .pixel_rst (pixel_rst),
        .vif       (vif)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [23:0] cap [4][HDISP];
    logic [23:0] bg  [4][HDISP];
    int          full_lines [4];
    int          prev_k = -1;
    int          prev_x = 0;
    logic        p_hs = 1'b1, p_vs = 1'b1, p_blank = 1'b0;
    bit          chk_sync = 0;
    bit          bg_rand  = 0;
    int          chg_line = -1;
    logic [9:0]  chg_x    = '0;
    int          rst_line = -1;
    int          bm_fill  = 16;

    // One pixel clock; output seen afterwards belongs to the previous step's input.
    task automatic step(input logic hs, input logic vs, input logic blank,
                        input logic [23:0] rgb, input int k, input int x);
        vif.in_hs    = hs;
        vif.in_vs    = vs;
        vif.in_blank = blank;
        vif.in_rgb   = rgb;
        if (bm_fill < 16) begin
            vif.bm_we    = 1'b1;
            vif.bm_addr  = 4'(bm_fill);
            vif.bm_wdata = 32'hFFFFFFFF;
            bm_fill++;
        end else begin
            vif.bm_we = 1'b0;
        end
        @(posedge pixel_clk);
        #1;
        if (prev_k >= 0) cap[prev_k][prev_x] = vif.out_rgb;
        if (chk_sync) begin
            check_val("hs_delay", {31'd0, vif.out_hs}, {31'd0, p_hs});
            check_val("vs_delay", {31'd0, vif.out_vs}, {31'd0, p_vs});
            check_val("blank_delay", {31'd0, vif.out_blank}, {31'd0, p_blank});
            if (!p_blank) check_val("blank_rgb", {8'd0, vif.out_rgb}, 32'd0);
        end
        p_hs    = hs;
        p_vs    = vs;
        p_blank = blank;
        prev_k  = k;
        prev_x  = x;
    endtask

    task automatic line(input int y);
        int k;
        int n;
        logic [23:0] rgb;
        k = -1;
        for (int i = 0; i < 4; i++) if (full_lines[i] == y) k = i;
        if (y == chg_line) vif.cursor_x = chg_x;
        step(1'b0, 1'b1, 1'b0, 24'd0, -1, 0);
        step(1'b1, 1'b1, 1'b0, 24'd0, -1, 0);
        n = (k >= 0) ? HDISP : 1;
        for (int x = 0; x < n; x++) begin
            rgb = bg_rand ? 24'($urandom) : BG;
            if (k >= 0) bg[k][x] = rgb;
            if (y == rst_line && x == 400) begin
                pixel_rst = 1'b1;
                #1;
                check_val("rst_out_hs", {31'd0, vif.out_hs}, 32'd1);
                check_val("rst_out_vs", {31'd0, vif.out_vs}, 32'd1);
                check_val("rst_out_blank", {31'd0, vif.out_blank}, 32'd0);
                check_val("rst_out_rgb", {8'd0, vif.out_rgb}, 32'd0);
            end
            if (y == rst_line && x == 404) begin
                pixel_rst = 1'b0;
                bm_fill   = 0;
            end
            step(1'b1, 1'b1, 1'b1, rgb, k, x);
        end
        step(1'b1, 1'b1, 1'b0, 24'd0, -1, 0);
        step(1'b1, 1'b1, 1'b0, 24'd0, -1, 0);
    endtask

    task automatic frame();
        repeat (3) step(1'b1, 1'b0, 1'b0, 24'd0, -1, 0);
        repeat (2) step(1'b1, 1'b1, 1'b0, 24'd0, -1, 0);
        for (int y = 0; y < VDISP; y++) line(y);
    endtask

    task automatic bm_write(input logic [3:0] addr, input logic [31:0] data);
        vif.bm_we    = 1'b1;
        vif.bm_addr  = addr;
        vif.bm_wdata = data;
        @(posedge pixel_clk);
        #1;
        vif.bm_we = 1'b0;
    endtask

    task automatic set_lines(input int a, input int b, input int c, input int d);
        full_lines[0] = a;
        full_lines[1] = b;
        full_lines[2] = c;
        full_lines[3] = d;
    endtask

    initial begin
        // Inputs busy during reset: outputs must still hold reset values.
        vif.in_hs        = 1'b0;
        vif.in_vs        = 1'b0;
        vif.in_blank     = 1'b1;
        vif.in_rgb       = 24'hFFFFFF;
        vif.cursor_x     = '0;
        vif.cursor_y     = '0;
        vif.cursor_en    = 1'b0;
        vif.cursor_color = GREEN;
        vif.bm_we        = 1'b0;
        vif.bm_addr      = '0;
        vif.bm_wdata     = '0;
        set_lines(-1, -1, -1, -1);
        repeat (3) @(posedge pixel_clk);
        #1;
        check_val("reset_hs", {31'd0, vif.out_hs}, 32'd1);
        check_val("reset_vs", {31'd0, vif.out_vs}, 32'd1);
        check_val("reset_blank", {31'd0, vif.out_blank}, 32'd0);
        check_val("reset_rgb", {8'd0, vif.out_rgb}, 32'd0);
        vif.in_hs    = 1'b1;
        vif.in_vs    = 1'b1;
        vif.in_blank = 1'b0;
        vif.in_rgb   = '0;
        pixel_rst    = 1'b0;
        @(posedge pixel_clk);
        #1;

        // Pass-through with cursor disabled (bitmap non-zero at 0,0).
        for (int r = 0; r < 16; r++) bm_write(4'(r), 32'h55555555);
        bg_rand  = 1;
        chk_sync = 1;
        set_lines(0, 240, -1, -1);
        frame();
        chk_sync = 0;
        bg_rand  = 0;
        for (int x = 0; x < HDISP; x++) begin
            check_val("pass_y0", {8'd0, cap[0][x]}, {8'd0, bg[0][x]});
            check_val("pass_y240", {8'd0, cap[1][x]}, {8'd0, bg[1][x]});
        end

        // Basic cursor, code 01 everywhere.
        vif.cursor_x  = 10'd100;
        vif.cursor_y  = 9'd50;
        vif.cursor_en = 1'b1;
        set_lines(49, 50, 65, 66);
        frame();
        check_val("basic_y50_x99", {8'd0, cap[1][99]}, {8'd0, BG});
        check_val("basic_y50_x100", {8'd0, cap[1][100]}, {8'd0, GREEN});
        check_val("basic_y50_x115", {8'd0, cap[1][115]}, {8'd0, GREEN});
        check_val("basic_y50_x116", {8'd0, cap[1][116]}, {8'd0, BG});
        check_val("basic_y65_x100", {8'd0, cap[2][100]}, {8'd0, GREEN});
        check_val("basic_y65_x115", {8'd0, cap[2][115]}, {8'd0, GREEN});
        check_val("basic_y49_x100", {8'd0, cap[0][100]}, {8'd0, BG});
        check_val("basic_y66_x100", {8'd0, cap[3][100]}, {8'd0, BG});

        // All four codes on row 0.
        bm_write(4'd0, 32'h000000E4);
        set_lines(50, -1, -1, -1);
        frame();
        check_val("code00", {8'd0, cap[0][100]}, {8'd0, BG});
        check_val("code01", {8'd0, cap[0][101]}, {8'd0, GREEN});
        check_val("code10", {8'd0, cap[0][102]}, 32'h00EDCBA9);
        check_val("code11", {8'd0, cap[0][103]}, {8'd0, WHITE});
        check_val("code_x104", {8'd0, cap[0][104]}, {8'd0, BG});

        // Clipping at the bottom-right corner.
        for (int r = 0; r < 16; r++) bm_write(4'(r), 32'hFFFFFFFF);
        vif.cursor_x = 10'd792;
        vif.cursor_y = 9'd472;
        set_lines(472, 479, 0, 7);
        frame();
        check_val("clip_y472_x791", {8'd0, cap[0][791]}, {8'd0, BG});
        check_val("clip_y472_x792", {8'd0, cap[0][792]}, {8'd0, WHITE});
        check_val("clip_y472_x799", {8'd0, cap[0][799]}, {8'd0, WHITE});
        check_val("clip_y472_x0", {8'd0, cap[0][0]}, {8'd0, BG});
        check_val("clip_y472_x7", {8'd0, cap[0][7]}, {8'd0, BG});
        check_val("clip_y479_x799", {8'd0, cap[1][799]}, {8'd0, WHITE});
        check_val("clip_y479_x0", {8'd0, cap[1][0]}, {8'd0, BG});
        check_val("clip_y0_x792", {8'd0, cap[2][792]}, {8'd0, BG});
        check_val("clip_y0_x0", {8'd0, cap[2][0]}, {8'd0, BG});
        check_val("clip_y7_x799", {8'd0, cap[3][799]}, {8'd0, BG});

        // Mid-frame position change only takes effect next frame.
        vif.cursor_x = 10'd100;
        vif.cursor_y = 9'd190;
        chg_line     = 200;
        chg_x        = 10'd300;
        set_lines(195, 201, -1, -1);
        frame();
        chg_line = -1;
        check_val("tear_f1_y195_x100", {8'd0, cap[0][100]}, {8'd0, WHITE});
        check_val("tear_f1_y195_x300", {8'd0, cap[0][300]}, {8'd0, BG});
        check_val("tear_f1_y201_x100", {8'd0, cap[1][100]}, {8'd0, WHITE});
        check_val("tear_f1_y201_x300", {8'd0, cap[1][300]}, {8'd0, BG});
        set_lines(195, -1, -1, -1);
        frame();
        check_val("tear_f2_y195_x300", {8'd0, cap[0][300]}, {8'd0, WHITE});
        check_val("tear_f2_y195_x100", {8'd0, cap[0][100]}, {8'd0, BG});

        // Reset in the middle of line 240; bitmap refilled right after release.
        vif.cursor_x = 10'd390;
        vif.cursor_y = 9'd230;
        rst_line     = 240;
        set_lines(235, 240, 241, -1);
        frame();
        rst_line = -1;
        check_val("rst_pre_y235_x400", {8'd0, cap[0][400]}, {8'd0, WHITE});
        check_val("rst_pre_y240_x395", {8'd0, cap[1][395]}, {8'd0, WHITE});
        check_val("rst_y240_x403", {8'd0, cap[1][403]}, 32'd0);
        check_val("rst_y240_x404", {8'd0, cap[1][404]}, {8'd0, BG});
        check_val("rst_y240_x405", {8'd0, cap[1][405]}, {8'd0, BG});
        check_val("rst_y241_x0", {8'd0, cap[2][0]}, {8'd0, BG});
        check_val("rst_y241_x400", {8'd0, cap[2][400]}, {8'd0, BG});
        set_lines(235, -1, -1, -1);
        frame();
        check_val("rst_next_y235_x400", {8'd0, cap[0][400]}, {8'd0, WHITE});
        check_val("rst_next_y235_x389", {8'd0, cap[0][389]}, {8'd0, BG});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
